// File: rtl/uart_ram_loader.sv
// UART (8N1) program loader: a length byte L, then N=L+1 big-endian 16-bit words written to RAM at 0..N-1.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte and expose the chk_err output.
module uart_ram_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic                  load_start,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_w_en,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
`ifdef LOADER_CHECKSUM_EN
   output logic                  chk_err,
`endif
   output logic                  frame_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = ADDR_WIDTH + 1;
   localparam int HI_W  = DATA_WIDTH - 8;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   // ------------------------------------------------------------------
   // rx synchroniser; rx_prev_reg gives the falling-edge reference
   // ------------------------------------------------------------------
   logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   // ------------------------------------------------------------------
   // UART receiver
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t        rx_state_reg, rx_state_next;
   logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             byte_valid;
   logic             stop_err;
   logic [7:0]       rx_byte;

   assign rx_byte = shift_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state_reg <= RX_IDLE;
         clk_cnt_reg  <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
      end else begin
         rx_state_reg <= rx_state_next;
         clk_cnt_reg  <= clk_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      clk_cnt_next  = clk_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      byte_valid    = 1'b0;
      stop_err      = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            if (rx_prev_reg && !rx_sync_reg) begin
               rx_state_next = RX_START;
               clk_cnt_next  = '0;
            end
         end
         RX_START: begin
            // a start bit that is high again at mid-bit was only a glitch
            if (clk_cnt_reg == HALF_LAST) begin
               clk_cnt_next  = '0;
               bit_idx_next  = '0;
               rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            end else begin
               clk_cnt_next = clk_cnt_reg + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (clk_cnt_reg == FULL_LAST) begin
               clk_cnt_next = '0;
               shift_next   = {rx_sync_reg, shift_reg[7:1]};
               bit_idx_next = bit_idx_reg + 3'd1;
               if (bit_idx_reg == 3'd7) begin
                  rx_state_next = RX_STOP;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (clk_cnt_reg == FULL_LAST) begin
               clk_cnt_next  = '0;
               rx_state_next = RX_IDLE;
               if (rx_sync_reg) begin
                  byte_valid = 1'b1;
               end else begin
                  stop_err = 1'b1;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + CNT_W'(1);
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      L_IDLE, L_LEN, L_HI, L_LO, L_WRITE,
`ifdef LOADER_CHECKSUM_EN
      L_CHK,
`endif
      L_DONE
   } ld_state_t;

   ld_state_t             ld_state_reg, ld_state_next;
   logic [IDX_W-1:0]      word_idx_reg, word_idx_next;
   logic [IDX_W-1:0]      word_cnt_reg, word_cnt_next;
   logic [IDX_W-1:0]      idx_inc;
   logic [HI_W-1:0]       hi_reg, hi_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  frame_err_reg, frame_err_next;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            chk_acc_reg, chk_acc_next;
   logic                  chk_err_reg, chk_err_next;
`endif

   // the index is one bit wider than the address so that N=256 terminates
   assign idx_inc = word_idx_reg + IDX_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_state_reg  <= L_IDLE;
         word_idx_reg  <= '0;
         word_cnt_reg  <= '0;
         hi_reg        <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         frame_err_reg <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_acc_reg   <= '0;
         chk_err_reg   <= 1'b0;
`endif
      end else begin
         ld_state_reg  <= ld_state_next;
         word_idx_reg  <= word_idx_next;
         word_cnt_reg  <= word_cnt_next;
         hi_reg        <= hi_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         frame_err_reg <= frame_err_next;
`ifdef LOADER_CHECKSUM_EN
         chk_acc_reg   <= chk_acc_next;
         chk_err_reg   <= chk_err_next;
`endif
      end
   end

   always_comb begin
      ld_state_next  = ld_state_reg;
      word_idx_next  = word_idx_reg;
      word_cnt_next  = word_cnt_reg;
      hi_next        = hi_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      frame_err_next = frame_err_reg;
`ifdef LOADER_CHECKSUM_EN
      chk_acc_next   = chk_acc_reg;
      chk_err_next   = chk_err_reg;
`endif
      case (ld_state_reg)
         L_IDLE: begin
            if (load_start) begin
               ld_state_next  = L_LEN;
               word_idx_next  = '0;
               frame_err_next = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               chk_err_next   = 1'b0;
`endif
            end
         end
         L_LEN: begin
            if (byte_valid) begin
               word_cnt_next = IDX_W'(rx_byte) + IDX_W'(1);
               ld_state_next = L_HI;
`ifdef LOADER_CHECKSUM_EN
               chk_acc_next  = rx_byte;
`endif
            end
         end
         L_HI: begin
            if (byte_valid) begin
               hi_next       = HI_W'(rx_byte);
               ld_state_next = L_LO;
`ifdef LOADER_CHECKSUM_EN
               chk_acc_next  = chk_acc_reg ^ rx_byte;
`endif
            end
         end
         L_LO: begin
            // address and data are captured here and then held until the next word
            if (byte_valid) begin
               addr_next     = word_idx_reg[ADDR_WIDTH-1:0];
               wdata_next    = {hi_reg, rx_byte};
               ld_state_next = L_WRITE;
`ifdef LOADER_CHECKSUM_EN
               chk_acc_next  = chk_acc_reg ^ rx_byte;
`endif
            end
         end
         L_WRITE: begin
            word_idx_next = idx_inc;
`ifdef LOADER_CHECKSUM_EN
            ld_state_next = (idx_inc == word_cnt_reg) ? L_CHK : L_HI;
`else
            ld_state_next = (idx_inc == word_cnt_reg) ? L_DONE : L_HI;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         L_CHK: begin
            if (byte_valid) begin
               if (rx_byte != chk_acc_reg) begin
                  chk_err_next = 1'b1;
               end
               ld_state_next = L_DONE;
            end
         end
`endif
         L_DONE: ld_state_next = L_IDLE;
         default: ld_state_next = L_IDLE;
      endcase
      // a bad stop bit is always recorded and abandons any load in progress
      if (stop_err) begin
         frame_err_next = 1'b1;
         ld_state_next  = L_IDLE;
      end
   end

   assign ram_addr  = addr_reg;
   assign ram_wdata = wdata_reg;
   assign ram_w_en  = (ld_state_reg == L_WRITE);
   assign done      = (ld_state_reg == L_DONE);
   assign busy      = (ld_state_reg != L_IDLE) && (ld_state_reg != L_DONE);
   assign cpu_hold  = busy;
   assign frame_err = frame_err_reg;
`ifdef LOADER_CHECKSUM_EN
   assign chk_err   = chk_err_reg;
`endif

endmodule

// File: tb/tb_uart_ram_loader.sv
// Self-checking bench for uart_ram_loader (CLKS_PER_BIT=4); honours LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_ram_loader;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx = 1'b1;
   logic        load_start = 1'b0;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_w_en, cpu_hold, busy, done, frame_err;
`ifdef LOADER_CHECKSUM_EN
   logic        chk_err;
`endif

   always #5 clk = ~clk;

   uart_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .rx(rx), .load_start(load_start),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
`ifdef LOADER_CHECKSUM_EN
      .chk_err(chk_err),
`endif
      .frame_err(frame_err)
   );

   typedef struct packed { logic [7:0] a; logic [15:0] d; } wr_t;

   typedef struct {
      string            name;
      int               arm;        // 0 none, 1 load_start, 2 load_start then rx glitch
      logic [7:0]       len;
      int               nsent;
      bit               restart;
      logic [2:0][15:0] w;
      int               exp_writes;
      int               exp_done;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          hold_gaps = 0;
   int          done_busy_err = 0;
   bit          expect_hold = 1'b0;
   wr_t         wr_q[$];
   logic [15:0] ram_mem [256];
   logic [15:0] ld_words [256];
   logic [7:0]  chk_flip = 8'h00;
   vec_t        vecs [4];

   // RAM model and output monitors, sampled mid-cycle
   always @(negedge clk) begin
      if (ram_w_en) begin
         wr_q.push_back('{a: ram_addr, d: ram_wdata});
         ram_mem[ram_addr] = ram_wdata;
      end
      if (done) begin
         done_cnt++;
         expect_hold = 1'b0;
         if (busy || cpu_hold) done_busy_err++;
      end else if (expect_hold && !cpu_hold) begin
         hold_gaps++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      cyc(1);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         cyc(CPB);
      end
      rx = 1'b1;
      cyc(2);
   endtask

   task automatic run_load(input int arm, input logic [7:0] len, input int nsent, input bit restart);
      logic [7:0] sum;
      sum = len;
      if (arm != 0) begin
         pulse_start();
         expect_hold = 1'b1;
      end
      if (arm == 2) begin
         rx = 1'b0;
         cyc(1);
         rx = 1'b1;
         cyc(12);
      end
      send_byte(len, 1'b1);
      for (int i = 0; i < nsent; i++) begin
         if (restart && i == 1) pulse_start();
         send_byte(ld_words[i][15:8], 1'b1);
         send_byte(ld_words[i][7:0], 1'b1);
         sum = sum ^ ld_words[i][15:8] ^ ld_words[i][7:0];
      end
`ifdef LOADER_CHECKSUM_EN
      if (arm != 0) send_byte(sum ^ chk_flip, 1'b1);
`endif
      cyc(6);
      $display("load arm=%0d len=0x%02h words_sent=%0d writes_seen=%0d", arm, len, nsent, wr_q.size());
   endtask

   // expected writes: addresses 0..n-1 carrying ld_words[0..n-1]
   task automatic check_writes(input string tag, input int n);
      int wrong;
      wrong = 0;
      chk({tag, "_count"}, wr_q.size(), n);
      for (int i = 0; i < n && i < wr_q.size(); i++)
         if (wr_q[i].a !== 8'(i) || wr_q[i].d !== ld_words[i]) wrong++;
      chk({tag, "_content"}, wrong, 0);
   endtask

   initial begin
      int d0;
      int n;
      int zero_addr;

      vecs[0] = '{"basic",   1, 8'h01, 2, 1'b0, {16'h0000, 16'hABCD, 16'h1234}, 2, 1};
      vecs[1] = '{"idle",    0, 8'h01, 2, 1'b0, {16'h0000, 16'hABCD, 16'h1234}, 0, 0};
      vecs[2] = '{"overrun", 2, 8'h00, 2, 1'b0, {16'h0000, 16'h5A5A, 16'hBEEF}, 1, 1};
      vecs[3] = '{"restart", 1, 8'h02, 3, 1'b1, {16'hC3C3, 16'h0F0F, 16'h8001}, 3, 1};

      for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;

      // reset state
      cyc(3);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_w_en", ram_w_en, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_frame_err", frame_err, 0);
`ifdef LOADER_CHECKSUM_EN
      chk("rst_chk_err", chk_err, 0);
`endif
      reset = 1'b1;
      cyc(3);

      // table-driven short loads
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 3; i++) ld_words[i] = vecs[v].w[i];
         wr_q.delete();
         d0 = done_cnt;
         run_load(vecs[v].arm, vecs[v].len, vecs[v].nsent, vecs[v].restart);
         chk({vecs[v].name, "_nwrites"}, wr_q.size(), vecs[v].exp_writes);
         for (int i = 0; i < vecs[v].exp_writes && i < wr_q.size(); i++) begin
            chk({vecs[v].name, "_addr"}, wr_q[i].a, i);
            chk({vecs[v].name, "_data"}, wr_q[i].d, vecs[v].w[i]);
         end
         chk({vecs[v].name, "_done"}, done_cnt - d0, vecs[v].exp_done);
         chk({vecs[v].name, "_busy_after"}, busy, 0);
      end

      // full depth: N=256, word i = i*0x0101
      for (int i = 0; i < 256; i++) ld_words[i] = 16'(i * 16'h0101);
      wr_q.delete();
      d0 = done_cnt;
      run_load(1, 8'hFF, 256, 1'b0);
      check_writes("full", 256);
      if (wr_q.size() > 0) begin
         chk("full_last_addr", wr_q[wr_q.size()-1].a, 8'hFF);
         chk("full_last_data", wr_q[wr_q.size()-1].d, 16'hFFFF);
      end
      zero_addr = 0;
      foreach (wr_q[i]) if (wr_q[i].a == 8'h00) zero_addr++;
      chk("full_no_wrap", zero_addr, 1);
      chk("full_done", done_cnt - d0, 1);

      // framing error on the third byte
      wr_q.delete();
      pulse_start();
      expect_hold = 1'b1;
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      expect_hold = 1'b0;
      send_byte(8'h34, 1'b0);
      chk("ferr_flag", frame_err, 1);
      chk("ferr_busy", busy, 0);
      chk("ferr_hold", cpu_hold, 0);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      cyc(6);
      chk("ferr_no_write", wr_q.size(), 0);
      pulse_start();
      chk("ferr_cleared", frame_err, 0);
      chk("ferr_rearmed", busy, 1);
      ld_words[0] = 16'h4242;
      d0 = done_cnt;
      run_load(1, 8'h00, 1, 1'b0);
      check_writes("ferr_reload", 1);
      chk("ferr_reload_done", done_cnt - d0, 1);

      // reset after the HI byte of word 1
      wr_q.delete();
      pulse_start();
      expect_hold = 1'b1;
      send_byte(8'h01, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      expect_hold = 1'b0;
      chk("mid_hold_before", cpu_hold, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_addr", ram_addr, 0);
      chk("mid_rst_wdata", ram_wdata, 0);
      chk("mid_rst_hold", cpu_hold, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_w_en", ram_w_en, 0);
      chk("mid_ram0_kept", ram_mem[0], 16'h1122);
      cyc(2);
      reset = 1'b1;
      cyc(2);
      wr_q.delete();
      ld_words[0] = 16'h7788;
      d0 = done_cnt;
      run_load(1, 8'h00, 1, 1'b0);
      check_writes("mid_fresh", 1);
      chk("mid_fresh_ram0", ram_mem[0], 16'h7788);
      chk("mid_fresh_done", done_cnt - d0, 1);

      // randomized loads against the word-list model
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) ld_words[i] = 16'($urandom);
         wr_q.delete();
         d0 = done_cnt;
         run_load(1, 8'(n - 1), n, 1'b0);
         check_writes("rand", n);
         chk("rand_done", done_cnt - d0, 1);
      end

`ifdef LOADER_CHECKSUM_EN
      ld_words[0] = 16'h1234;
      wr_q.delete();
      d0 = done_cnt;
      chk_flip = 8'h00;
      run_load(1, 8'h00, 1, 1'b0);
      check_writes("chk_good", 1);
      chk("chk_good_err", chk_err, 0);
      chk("chk_good_done", done_cnt - d0, 1);
      wr_q.delete();
      d0 = done_cnt;
      chk_flip = 8'h01;
      run_load(1, 8'h00, 1, 1'b0);
      chk("chk_bad_err", chk_err, 1);
      chk("chk_bad_done", done_cnt - d0, 1);
      chk("chk_bad_hold", cpu_hold, 0);
      chk_flip = 8'h00;
      run_load(1, 8'h00, 1, 1'b0);
      chk("chk_err_cleared", chk_err, 0);
`endif

      chk("hold_gaps", hold_gaps, 0);
      chk("done_while_busy", done_busy_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Serial program loader that fills the 256x16 main RAM from an external host over a UART line while the CPU is held off.
- It is the writer side of the RAM: the CPU datapath only reads RAM through MAR/MDR after boot, and this block supplies the contents in place of a static init file.
- Sits beside ram_inst0 and muxes onto its address/data/write-enable inputs while busy.
- Drives cpu_hold so the control unit stays in reset during a load.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); minimum legal value 4.
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 16, RAM word width; fixed at two bytes per word.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  UART receive line, idle high, asynchronous to clk.
- load_start  input  1  single-cycle pulse that arms a load.
- ram_addr  output  ADDR_WIDTH  RAM write address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_w_en  output  1  RAM write strobe, one cycle per word.
- cpu_hold  output  1  high while a load is in progress; holds the CPU in reset.
- busy  output  1  loader not in IDLE.
- done  output  1  one-cycle pulse on successful completion.
- frame_err  output  1  sticky; a stop bit was sampled low.

Behaviour:
- Reset (reset=0, asynchronous):
  - All state goes to IDLE.
  - ram_addr=0, ram_wdata=0, ram_w_en=0, cpu_hold=0, busy=0, done=0, frame_err=0.
  - Byte counters and the UART sampler are cleared.
- rx synchronisation: rx passes through a 2-flop synchroniser; its reset value is 1.
- UART receiver (8N1, LSB first):
  - A falling edge on the synchronised rx starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2; if rx is high there, the edge is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT cycles after that mid-start point.
  - The stop bit is sampled at its midpoint. A good stop bit produces a one-cycle byte_valid.
  - Stop bit low sets frame_err, produces no byte_valid, and aborts the load to IDLE.
- Loader FSM: IDLE -> LEN -> HI -> LO -> WRITE -> (HI | DONE) -> IDLE.
  - IDLE: bytes on rx are ignored. load_start moves to LEN, sets busy=1 and cpu_hold=1, clears frame_err, and zeroes the word index.
  - LEN: the first byte L sets the word count N = L+1 (range 1..256).
  - HI: the byte is latched as data[15:8].
  - LO: the byte is latched as data[7:0].
  - WRITE: exactly one cycle. ram_w_en=1, ram_addr=word index, ram_wdata={hi,lo}. The index then increments. If the index reaches N, go to DONE; otherwise return to HI.
  - DONE: one cycle. done=1. busy and cpu_hold drop in the same cycle, and the FSM returns to IDLE.
- Addressing: words are written at addresses 0..N-1. The index is 9 bits wide internally so that N=256 terminates; only the low 8 bits drive ram_addr.
- ram_addr and ram_wdata hold their last written values outside WRITE.
- load_start while busy is ignored; there is no restart.
- Reset mid-load: immediate return to IDLE. Words already written stay in RAM, and cpu_hold drops.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds state CHK after the final WRITE, replacing the WRITE -> DONE transition.
  - The host sends one trailing byte equal to the XOR of L and every data byte.
  - On a match, DONE pulses done. On a mismatch, a sticky output chk_err (1 bit, reset 0, cleared by load_start) is set; done still pulses and cpu_hold still drops.
- Undefined: the CHK state and the chk_err port do not exist, and no trailing byte is expected.

Test Plan (CLKS_PER_BIT=4):
- Basic load: load_start, then bytes 0x01, 0x12, 0x34, 0xAB, 0xCD.
  - ram_w_en pulses twice: addr0=0x1234, addr1=0xABCD.
  - done pulses once; cpu_hold is high from load_start to done.
- Full depth: L=0xFF followed by 512 bytes with pattern word i = i*0x0101.
  - 256 writes, last at addr 0xFF = 0xFFFF.
  - No write with addr wrap to 0; done pulses.
- Framing error: the third byte is sent with stop bit 0.
  - frame_err=1, busy=0, no further ram_w_en.
  - The next load_start clears frame_err.
- Idle and glitch immunity:
  - Bytes sent without load_start produce no ram_w_en.
  - An rx low pulse of 1 clock produces no byte.
  - load_start asserted mid-load does not reset the word index.
- Reset mid-load: assert reset after the HI byte of word 1.
  - All outputs return to reset values at once; addr0 keeps its value.
  - A fresh load then works.
- LOADER_CHECKSUM_EN:
  - Stream 0x00, 0x12, 0x34, then checksum 0x26: done, chk_err=0.
  - Same stream with checksum 0x27: chk_err=1, done still pulses.
